ads1115_i2c_target: RTL

- Synthesizable I2C target (responder) emulating the ADS1115 register map, 7-bit address, pointer/config/conversion registers.
- It is the far end of the I2C master plus ADC-sequencer path: it sits on an scl/sda pair in place of a physical ADC.
- Used for hardware-in-the-loop and simulation of the converter control loop.
- Conversion results come from a parallel sample input, so the flying-cap and Vout sense values are scriptable.

---
 rtl/ads1115_i2c_target_pkg.sv | 33 +++
 rtl/ads1115_i2c_target_i2c_bus_sync.sv | 40 ++++
 rtl/ads1115_i2c_target.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ads1115_i2c_target_pkg.sv
// Shared constants, FSM encoding and bit-select helper for the ADS1115 I2C target model.
package ads1115_i2c_target_pkg;

    localparam logic [1:0] PTR_CONV = 2'd0;
    localparam logic [1:0] PTR_CFG  = 2'd1;
    localparam logic [1:0] PTR_LO   = 2'd2;
    localparam logic [1:0] PTR_HI   = 2'd3;

    localparam int CFG_OS     = 15;
    localparam int CFG_MODE   = 8;
    localparam int CFG_MUX_LO = 12;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ADDR       = 4'd1,
        ADDR_ACK   = 4'd2,
        PTR        = 4'd3,
        PTR_ACK    = 4'd4,
        WR_MSB     = 4'd5,
        WR_MSB_ACK = 4'd6,
        WR_LSB     = 4'd7,
        WR_LSB_ACK = 4'd8,
        RD_BYTE    = 4'd9,
        RD_ACK     = 4'd10,
        IGNORE     = 4'd11
    } state_e;

    // Bit idx (0 = first on the wire) of the MSB byte (lsb_sel=0) or LSB byte of a 16-bit word.
    function automatic logic rd_bit(input logic [15:0] data, input logic lsb_sel, input logic [2:0] idx);
        return data[{~lsb_sel, ~idx}];
    endfunction

endpackage

// File: rtl/ads1115_i2c_target_i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk_i and flags SCL edges plus START/STOP conditions.
module ads1115_i2c_target_i2c_bus_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_o
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;

    // Idle bus is high, so reset everything to 1 to avoid a phantom START/STOP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign sda_o      = sda_sync_q[1];
    assign scl_rise_o = scl_sync_q[1] & ~scl_prev_q;
    assign scl_fall_o = ~scl_sync_q[1] & scl_prev_q;
    assign start_o    = scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
    assign stop_o     = scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];

endmodule

// File: rtl/ads1115_i2c_target.sv
// ADS1115-compatible I2C target: pointer/config/conversion/threshold registers and a
// timed conversion engine that latches a parallel sample input.
module ads1115_i2c_target
    import ads1115_i2c_target_pkg::*;
#(
    parameter logic [6:0]  ADDRESS     = 7'b1001001,
    parameter int unsigned CONV_CYCLES = 216,
    parameter logic [15:0] CONFIG_RST  = 16'h8583
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe_o,
    input  logic [15:0] sample_i,
    output logic [2:0]  mux_o,
    output logic        busy_o,
    output logic        conv_done_o,
    output logic [15:0] config_o
);

    localparam int CNT_W = $clog2(CONV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);

    logic scl_rise_s, scl_fall_s, start_s, stop_s, sda_s;

    ads1115_i2c_target_i2c_bus_sync u_bus_sync (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise_o(scl_rise_s),
        .scl_fall_o(scl_fall_s),
        .start_o   (start_s),
        .stop_o    (stop_s),
        .sda_o     (sda_s)
    );

    state_e      state_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  rx_q;
    logic [7:0]  msb_q;
    logic [15:0] tx_q;
    logic        byte_sel_q;
    logic        rw_q;
    logic        mack_q;
    logic [1:0]  ptr_q;
    logic        sda_oe_q;
    logic        wr_en_q;
    logic [15:0] wr_data_q;

    logic [14:0] cfg_q;
    logic [15:0] conv_q;
    logic [15:0] lo_q;
    logic [15:0] hi_q;
    logic        busy_q;
    logic        conv_done_q;
    logic [CNT_W-1:0] conv_cnt_q;

    logic [15:0] reg_rd_s;
    logic        byte_done_s;
    logic        conv_start_s;
    logic        conv_halt_s;

    // Read mux for the register addressed by the pointer; config bit 15 reflects ~busy.
    always_comb begin
        reg_rd_s = conv_q;
        case (ptr_q)
            PTR_CONV: reg_rd_s = conv_q;
            PTR_CFG:  reg_rd_s = {~busy_q, cfg_q};
            PTR_LO:   reg_rd_s = lo_q;
            PTR_HI:   reg_rd_s = hi_q;
            default:  reg_rd_s = conv_q;
        endcase
    end

    assign byte_done_s = (bit_cnt_q == 4'd8);

    // Protocol FSM: bits are sampled on SCL rise, SDA drive is updated only after SCL fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            rx_q       <= 8'h00;
            msb_q      <= 8'h00;
            tx_q       <= 16'h0000;
            byte_sel_q <= 1'b0;
            rw_q       <= 1'b0;
            mack_q     <= 1'b0;
            ptr_q      <= PTR_CONV;
            sda_oe_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 16'h0000;
        end else begin
            wr_en_q <= 1'b0;
            if (start_s) begin
                state_q   <= ADDR;
                bit_cnt_q <= 4'd0;
                sda_oe_q  <= 1'b0;
            end else if (stop_s) begin
                state_q  <= IDLE;
                sda_oe_q <= 1'b0;
            end else begin
                if (scl_rise_s) begin
                    rx_q      <= {rx_q[6:0], sda_s};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                    mack_q    <= ~sda_s;
                end
                if (scl_fall_s) begin
                    case (state_q)
                        ADDR: begin
                            if (byte_done_s && rx_q[7:1] == ADDRESS) begin
                                rw_q     <= rx_q[0];
                                sda_oe_q <= 1'b1;
                                state_q  <= ADDR_ACK;
                            end else if (byte_done_s) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= IGNORE;
                            end else begin
                                sda_oe_q <= 1'b0;
                            end
                        end
                        ADDR_ACK: begin
                            bit_cnt_q <= 4'd0;
                            if (rw_q) begin
                                // Snapshot here keeps both read bytes from one conversion.
                                tx_q       <= reg_rd_s;
                                byte_sel_q <= 1'b0;
                                sda_oe_q   <= ~reg_rd_s[15];
                                state_q    <= RD_BYTE;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= PTR;
                            end
                        end
                        PTR: begin
                            if (byte_done_s) begin
                                ptr_q    <= rx_q[1:0];
                                sda_oe_q <= 1'b1;
                                state_q  <= PTR_ACK;
                            end
                        end
                        PTR_ACK: begin
                            bit_cnt_q <= 4'd0;
                            sda_oe_q  <= 1'b0;
                            state_q   <= WR_MSB;
                        end
                        WR_MSB: begin
                            if (byte_done_s) begin
                                msb_q    <= rx_q;
                                sda_oe_q <= 1'b1;
                                state_q  <= WR_MSB_ACK;
                            end
                        end
                        WR_MSB_ACK: begin
                            bit_cnt_q <= 4'd0;
                            sda_oe_q  <= 1'b0;
                            state_q   <= WR_LSB;
                        end
                        WR_LSB: begin
                            if (byte_done_s) begin
                                wr_data_q <= {msb_q, rx_q};
                                wr_en_q   <= 1'b1;
                                sda_oe_q  <= 1'b1;
                                state_q   <= WR_LSB_ACK;
                            end
                        end
                        WR_LSB_ACK: begin
                            sda_oe_q <= 1'b0;
                            state_q  <= IGNORE;
                        end
                        RD_BYTE: begin
                            if (byte_done_s) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= RD_ACK;
                            end else begin
                                sda_oe_q <= ~rd_bit(tx_q, byte_sel_q, bit_cnt_q[2:0]);
                            end
                        end
                        RD_ACK: begin
                            if (mack_q) begin
                                bit_cnt_q  <= 4'd0;
                                byte_sel_q <= ~byte_sel_q;
                                sda_oe_q   <= ~rd_bit(tx_q, ~byte_sel_q, 3'd0);
                                state_q    <= RD_BYTE;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= IGNORE;
                            end
                        end
                        default: sda_oe_q <= 1'b0;
                    endcase
                end
            end
        end
    end

    assign conv_start_s = wr_en_q && (ptr_q == PTR_CFG) &&
                          (wr_data_q[CFG_OS] || !wr_data_q[CFG_MODE]);
    assign conv_halt_s  = wr_en_q && (ptr_q == PTR_CFG) && wr_data_q[CFG_MODE] &&
                          !wr_data_q[CFG_OS] && !cfg_q[CFG_MODE];

    // Register commits and conversion engine; a latch in the same cycle as a new start completes first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q       <= CONFIG_RST[14:0];
            conv_q      <= 16'h0000;
            lo_q        <= 16'h8000;
            hi_q        <= 16'h7FFF;
            busy_q      <= 1'b0;
            conv_done_q <= 1'b0;
            conv_cnt_q  <= '0;
        end else begin
            conv_done_q <= 1'b0;
            if (wr_en_q) begin
                case (ptr_q)
                    PTR_CFG: cfg_q <= wr_data_q[14:0];
                    PTR_LO:  lo_q  <= wr_data_q;
                    PTR_HI:  hi_q  <= wr_data_q;
                    default: ;
                endcase
            end
            if (busy_q && conv_cnt_q == CNT_LAST) begin
                conv_q      <= sample_i;
                conv_done_q <= 1'b1;
                conv_cnt_q  <= '0;
                busy_q      <= ~cfg_q[CFG_MODE];
            end else if (busy_q) begin
                conv_cnt_q <= conv_cnt_q + CNT_W'(1);
            end else begin
                conv_cnt_q <= '0;
            end
            if (conv_start_s) begin
                busy_q     <= 1'b1;
                conv_cnt_q <= '0;
            end else if (conv_halt_s) begin
                busy_q     <= 1'b0;
                conv_cnt_q <= '0;
            end
        end
    end

    assign sda_oe_o    = sda_oe_q;
    assign busy_o      = busy_q;
    assign conv_done_o = conv_done_q;
    assign config_o    = {~busy_q, cfg_q};
    assign mux_o       = cfg_q[CFG_MUX_LO +: 3];

endmodule
